reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of upstream register-interface requesters; SHALL be at least 2.
REQ-002 Parameter TIMEOUT, default 16: cycles a granted transfer SHALL wait for downstream ready before being aborted; SHALL be at least 1.
REQ-003 Port clk_i  in  1: single clock; all logic SHALL be rising-edge clocked.
REQ-004 Port rst_i  in  1: reset, asynchronous and active-high.
REQ-005 Port reg_req_i  in  N_REQ x reg_req_t: per-requester request (valid, write, addr, wdata, wstrb).
REQ-006 Port reg_rsp_o  out  N_REQ x reg_rsp_t: per-requester response (ready, rdata, error).
REQ-007 Port reg_req_o  out  reg_req_t: shared downstream request.
REQ-008 Port reg_rsp_i  in  reg_rsp_t: shared downstream response.
REQ-009 Port grant_o  out  $clog2(N_REQ): index of the granted requester; meaningful only while busy_o=1.
REQ-010 Port busy_o  out  1: high while a transfer is granted.
REQ-011 Port timeout_o  out  1: one-cycle pulse in the cycle a transfer is aborted by timeout.

Function
REQ-012 FSM states SHALL be IDLE and BUSY.
REQ-013 In IDLE, when any reg_req_i[k].valid=1, the block SHALL latch the round-robin winner into grant_o, clear the timeout counter and enter BUSY next cycle; reg_req_o.valid SHALL be 0 in IDLE.
REQ-014 Round-robin SHALL search upward from (last granted index + 1) modulo N_REQ, wrapping from N_REQ-1 to 0; after reset the search SHALL start at index 0.
REQ-015 In BUSY, reg_req_o SHALL equal reg_req_i[grant_o] combinationally; all other reg_rsp_o[j] SHALL have ready=0, error=0 and rdata=0.
REQ-016 In BUSY, reg_rsp_o[grant_o] SHALL equal reg_rsp_i combinationally, and the transfer SHALL complete in the cycle reg_rsp_i.ready=1. The FSM SHALL return to IDLE next cycle.
REQ-017 Minimum latency from requester valid to ready SHALL be 2 cycles. The minimum spacing of consecutive grants SHALL be 2 cycles, because one IDLE cycle is always inserted.
REQ-018 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL increment each BUSY cycle in which reg_rsp_i.ready=0.
REQ-019 When the counter equals TIMEOUT-1 and reg_rsp_i.ready=0, the following SHALL happen in the same cycle, followed by IDLE next cycle:
- drive reg_rsp_o[grant_o].ready=1, error=1, rdata=0;
- drive reg_req_o.valid=0;
- pulse timeout_o=1.
REQ-020 Downstream ready and timeout expiry in the same cycle: the downstream response SHALL win, and timeout_o SHALL stay 0.
REQ-021 If the granted requester drops valid while BUSY (protocol violation), reg_req_o.valid SHALL follow it to 0 and the FSM SHALL return to IDLE next cycle without a response.
REQ-022 Requests arriving while BUSY SHALL be held off (ready=0) and considered at the next IDLE arbitration.
REQ-023 The last-granted index SHALL update only on entry to BUSY.

Reset
REQ-024 While rst_i=1 the outputs SHALL be forced immediately, independent of clk_i:
- FSM to IDLE, round-robin pointer and timeout counter to 0;
- grant_o=0, busy_o=0, timeout_o=0;
- reg_req_o all-zero, every reg_rsp_o all-zero.
REQ-025 A reset asserted during BUSY SHALL drop the transfer with no response to the requester.

Structure
REQ-026 reg_req_t and reg_rsp_t SHALL come from the shared global typedef include.
REQ-027 The FSM state enum SHALL be local to the module.
REQ-028 The timeout counter SHALL be a single sub-module, reg_timeout_counter (enable, clear, expire output).
REQ-029 The round-robin picker SHALL be inline logic in the arbiter.

Verification
REQ-030 N_REQ=2, requester 0 valid write addr 0x10, downstream ready on the 1st BUSY cycle -> reg_req_o.write=1 addr 0x10; reg_rsp_o[0].ready=1 two cycles after valid; error=0.
REQ-031 Both requesters continuously valid, downstream always ready -> grants alternate 0,1,0,1; each requester completes once per 4 cycles.
REQ-032 TIMEOUT=4, downstream never ready, requester 1 reads -> in BUSY cycle 4: reg_rsp_o[1].ready=1, error=1, rdata=0, timeout_o pulse; then IDLE.
REQ-033 TIMEOUT=4, downstream ready exactly in BUSY cycle 4 with rdata 0xA5A5A5A5 -> rdata passed through, error=0, timeout_o=0.
REQ-034 rst_i asserted mid-BUSY -> busy_o=0 and reg_req_o.valid=0 immediately, before the next clock edge; after release, the first grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared register-bus request/response types for the arbiter and its users.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package reg_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              error;
  } reg_rsp_t;

  // Response handed to a requester whose transfer was abandoned by timeout.
  localparam reg_rsp_t TIMEOUT_RSP = '{ready: 1'b1, rdata: '0, error: 1'b1};

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Bundle of upstream/downstream register-bus signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
interface reg_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  import reg_bus_arbiter_pkg::*;

  localparam int GRANT_W = $clog2(N_REQ);

  reg_req_t [N_REQ-1:0] reg_req_i;
  reg_rsp_t [N_REQ-1:0] reg_rsp_o;
  reg_req_t             reg_req_o;
  reg_rsp_t             reg_rsp_i;
  logic [GRANT_W-1:0]   grant_o;
  logic                 busy_o;
  logic                 timeout_o;

  // Environment side: drives upstream requests and the downstream response.
  modport master (
    output reg_req_i, reg_rsp_i,
    input  reg_rsp_o, reg_req_o, grant_o, busy_o, timeout_o
  );

  // Arbiter side.
  modport slave (
    input  reg_req_i, reg_rsp_i,
    output reg_rsp_o, reg_req_o, grant_o, busy_o, timeout_o
  );

endinterface

// File: rtl/reg_timeout_counter.sv
// Counts stalled cycles of a granted transfer and flags the cycle it must be abandoned.
// Latency: expire_o is combinational from the count and en_i.
// Backpressure: none; clr_i has priority over en_i.
module reg_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance on every stalled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The TIMEOUT-th stalled cycle is the one that gets aborted.
  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one downstream register bus among N_REQ requesters.
// Latency: grant one cycle after valid; response passes through combinationally while BUSY.
// Backpressure: non-granted requesters see ready=0; stalled transfers abort after TIMEOUT cycles.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  reg_bus_arbiter_if.slave bus
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        ptr_q;
  logic                 busy_q;

  logic [GW-1:0]        win;
  logic                 any_vld;
  logic [GW:0]          idx;
  reg_req_t             gnt_req;
  logic                 tmo_en;
  logic                 tmo_expire;
  logic                 done;
  reg_req_t             req_out;
  reg_rsp_t [N_REQ-1:0] rsp_out;
  logic                 tmo_pulse;

  // Round-robin pick: first valid requester at or after ptr_q, wrapping past N_REQ-1.
  // Iterating downward lets the lowest offset from ptr_q win.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_REQ)) begin
        idx = idx - (GW+1)'(N_REQ);
      end
      if (bus.reg_req_i[idx[GW-1:0]].valid) begin
        any_vld = 1'b1;
        win     = idx[GW-1:0];
      end
    end
  end

  assign gnt_req = bus.reg_req_i[grant_q];
  assign tmo_en  = (state_q == BUSY) && !bus.reg_rsp_i.ready;
  // A transfer ends on downstream ready, on timeout, or when the requester abandons it.
  assign done    = !gnt_req.valid || bus.reg_rsp_i.ready || tmo_expire;

  reg_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (tmo_en),
    .clr_i    (state_q == IDLE),
    .expire_o (tmo_expire)
  );

  // Route the granted request down and the response back; everything is zero while idle.
  // A downstream ready in the expiry cycle wins because tmo_expire already requires ready=0.
  always_comb begin
    req_out   = '0;
    rsp_out   = '0;
    tmo_pulse = 1'b0;
    if (state_q == BUSY) begin
      req_out = gnt_req;
      if (gnt_req.valid) begin
        if (tmo_expire) begin
          req_out.valid     = 1'b0;
          rsp_out[grant_q]  = TIMEOUT_RSP;
          tmo_pulse         = 1'b1;
        end else begin
          rsp_out[grant_q]  = bus.reg_rsp_i;
        end
      end
    end
  end

  // Arbitration FSM: grant from IDLE, drop back to IDLE the cycle after a transfer ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
            grant_q <= win;
            ptr_q   <= (win == GW'(N_REQ - 1)) ? '0 : win + GW'(1);
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_req_o = req_out;
  assign bus.reg_rsp_o = rsp_out;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = tmo_pulse;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed corner cases, then randomized traffic against a transaction model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;

  localparam int NR  = 2;
  localparam int TMO = 4;

  logic clk_i = 1'b0;
  logic rst_i;

  reg_bus_arbiter_if #(.N_REQ(NR)) bus ();

  reg_bus_arbiter #(
    .N_REQ   (NR),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Transaction model: who owns the bus (-1 = nobody), how many stalled cycles it has
  // accumulated, and where the next round-robin search begins.
  int m_owner;
  int m_wait;
  int m_next;

  int g_seq[$];
  int done_cnt[NR];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reg_req_t mk_req(input logic vld, input logic wr,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    reg_req_t r;
    r.valid = vld;
    r.write = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = 4'hF;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_wait  = 0;
    m_next  = 0;
  endtask

  // Advance the model across one clock edge using the inputs present before it.
  task automatic model_step();
    reg_req_t g;
    if (m_owner < 0) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_next + i) % NR;
        if (bus.reg_req_i[k].valid) begin
          m_owner = k;
          m_wait  = 0;
          m_next  = (k + 1) % NR;
          break;
        end
      end
    end else begin
      g = bus.reg_req_i[m_owner];
      if (!g.valid || bus.reg_rsp_i.ready || m_wait == TMO - 1) begin
        m_owner = -1;
      end else begin
        m_wait++;
      end
    end
  endtask

  // Compare every output against what the model says this cycle should show.
  task automatic compare_all();
    reg_req_t            e_req;
    reg_rsp_t [NR-1:0]   e_rsp;
    logic                e_tmo;
    logic                e_busy;
    e_req  = '0;
    e_rsp  = '0;
    e_tmo  = 1'b0;
    e_busy = !rst_i && (m_owner >= 0);
    if (e_busy) begin
      e_req = bus.reg_req_i[m_owner];
      if (e_req.valid) begin
        if (!bus.reg_rsp_i.ready && m_wait == TMO - 1) begin
          e_req.valid    = 1'b0;
          e_rsp[m_owner] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
          e_tmo          = 1'b1;
        end else begin
          e_rsp[m_owner] = bus.reg_rsp_i;
        end
      end
    end
    chk("busy_o", bus.busy_o, e_busy);
    chk("timeout_o", bus.timeout_o, e_tmo);
    chk("reg_req_o", bus.reg_req_o, e_req);
    for (int k = 0; k < NR; k++) begin
      chk("reg_rsp_o", bus.reg_rsp_o[k], e_rsp[k]);
    end
    if (e_busy) begin
      chk("grant_o", bus.grant_o, m_owner);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (rst_i) model_reset();
    else       model_step();
    #1;
  endtask

  task automatic settle_check();
    #3;
    compare_all();
  endtask

  task automatic drive_random();
    reg_req_t r;
    reg_rsp_t s;
    for (int k = 0; k < NR; k++) begin
      r.valid = ($urandom_range(0, 3) != 0);
      r.write = 1'($urandom_range(0, 1));
      r.addr  = $urandom;
      r.wdata = $urandom;
      r.wstrb = 4'($urandom_range(0, 15));
      bus.reg_req_i[k] = r;
    end
    s.ready = ($urandom_range(0, 2) == 0);
    s.rdata = $urandom;
    s.error = 1'($urandom_range(0, 1));
    bus.reg_rsp_i = s;
  endtask

  initial begin
    rst_i         = 1'b0;
    bus.reg_req_i = '0;
    bus.reg_rsp_i = '0;
    model_reset();
    for (int k = 0; k < NR; k++) done_cnt[k] = 0;

    // Reset values.
    #1 rst_i = 1'b1;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    chk("rst_req", bus.reg_req_o, 0);
    chk("rst_rsp", bus.reg_rsp_o, 0);
    tick();
    tick();
    rst_i = 1'b0;
    settle_check();

    // Single write from requester 0, downstream ready immediately.
    tick();
    bus.reg_req_i[0] = mk_req(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    bus.reg_rsp_i    = '{ready: 1'b1, rdata: 32'h0, error: 1'b0};
    settle_check();
    chk("a_idle_busy", bus.busy_o, 0);
    chk("a_idle_ready", bus.reg_rsp_o[0].ready, 0);
    tick();
    settle_check();
    chk("a_grant", bus.grant_o, 0);
    chk("a_write", bus.reg_req_o.write, 1);
    chk("a_addr", bus.reg_req_o.addr, 32'h10);
    chk("a_ready", bus.reg_rsp_o[0].ready, 1);
    chk("a_error", bus.reg_rsp_o[0].error, 0);
    tick();
    bus.reg_req_i[0] = '0;
    settle_check();
    chk("a_release", bus.busy_o, 0);

    // Requester 1 read, downstream never ready: abort in BUSY cycle TMO.
    tick();
    bus.reg_req_i[1] = mk_req(1'b1, 1'b0, 32'h20, 32'h0);
    bus.reg_rsp_i    = '{ready: 1'b0, rdata: 32'hDEAD_BEEF, error: 1'b0};
    settle_check();
    for (int c = 1; c <= TMO; c++) begin
      tick();
      settle_check();
      if (c < TMO) begin
        chk("b_wait_ready", bus.reg_rsp_o[1].ready, 0);
        chk("b_wait_timeout", bus.timeout_o, 0);
      end else begin
        chk("b_ready", bus.reg_rsp_o[1].ready, 1);
        chk("b_error", bus.reg_rsp_o[1].error, 1);
        chk("b_rdata", bus.reg_rsp_o[1].rdata, 0);
        chk("b_timeout", bus.timeout_o, 1);
        chk("b_req_valid", bus.reg_req_o.valid, 0);
      end
    end
    tick();
    bus.reg_req_i[1] = '0;
    settle_check();
    chk("b_release", bus.busy_o, 0);

    // Requester 0 read, downstream ready exactly in the expiry cycle: response wins.
    tick();
    bus.reg_req_i[0] = mk_req(1'b1, 1'b0, 32'h30, 32'h0);
    bus.reg_rsp_i    = '{ready: 1'b0, rdata: 32'hA5A5_A5A5, error: 1'b0};
    settle_check();
    for (int c = 1; c <= TMO; c++) begin
      tick();
      if (c == TMO) bus.reg_rsp_i.ready = 1'b1;
      settle_check();
      if (c == TMO) begin
        chk("c_ready", bus.reg_rsp_o[0].ready, 1);
        chk("c_rdata", bus.reg_rsp_o[0].rdata, 32'hA5A5_A5A5);
        chk("c_error", bus.reg_rsp_o[0].error, 0);
        chk("c_timeout", bus.timeout_o, 0);
      end
    end
    tick();
    bus.reg_req_i[0] = '0;
    bus.reg_rsp_i    = '0;
    settle_check();
    chk("c_release", bus.busy_o, 0);

    // Reset mid-transfer, then both requesters contend with downstream always ready.
    tick();
    bus.reg_req_i[0] = mk_req(1'b1, 1'b0, 32'h40, 32'h0);
    bus.reg_req_i[1] = mk_req(1'b1, 1'b1, 32'h44, 32'h55);
    settle_check();
    tick();
    settle_check();
    chk("d_busy", bus.busy_o, 1);
    chk("d_grant", bus.grant_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("d_rst_busy", bus.busy_o, 0);
    chk("d_rst_valid", bus.reg_req_o.valid, 0);
    chk("d_rst_rsp", bus.reg_rsp_o, 0);
    model_reset();
    compare_all();
    tick();
    rst_i = 1'b0;
    bus.reg_rsp_i.ready = 1'b1;
    settle_check();
    for (int c = 0; c < 8; c++) begin
      tick();
      settle_check();
      if (bus.busy_o) g_seq.push_back(int'(bus.grant_o));
      for (int k = 0; k < NR; k++) begin
        if (bus.reg_rsp_o[k].ready) done_cnt[k]++;
      end
    end
    chk("d_ngrants", g_seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("d_grant_seq", (i < g_seq.size()) ? g_seq[i] : -1, i % 2);
    end
    for (int k = 0; k < NR; k++) begin
      chk("d_completions", done_cnt[k], 2);
    end
    tick();
    bus.reg_req_i = '0;
    bus.reg_rsp_i = '0;
    settle_check();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      drive_random();
      rst_i = ($urandom_range(0, 199) == 0);
      settle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
